// File: rtl/ro_cnt_pkg.sv
// ---------------------------------------------------------------------------
// ro_cnt_pkg: shared state encoding and default sizes for the RO counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ro_cnt_pkg;

  localparam int RO_N_CH_DEF  = 2;
  localparam int RO_CNT_W_DEF = 32;
  localparam int RO_WIN_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } ro_state_t;

endpackage

`default_nettype wire

// File: rtl/ro_edge_sync.sv
// ---------------------------------------------------------------------------
// ro_edge_sync: 2-flop synchronizer plus a third flop for rising-edge detect.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ro_edge_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic edge_p
);

  // [0] = sync1, [1] = sync2, [2] = sync3
  logic [2:0] r_sh;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[1:0], d};
    end
  end

  assign edge_p = r_sh[1] & ~r_sh[2];

endmodule

`default_nettype wire

// File: rtl/ro_window_counter.sv
// ---------------------------------------------------------------------------
// ro_window_counter: window-gated N-channel RO edge counter with pairwise
// compare. Option macro RO_CNT_SATURATE_EN selects saturating counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ro_window_counter
  import ro_cnt_pkg::*;
#(
  parameter int N_CH  = RO_N_CH_DEF,
  parameter int CNT_W = RO_CNT_W_DEF,
  parameter int WIN_W = RO_WIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIN_W-1:0]      win_len,
  input  logic [N_CH-1:0]       ch_in,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic [N_CH-1:0]       sat,
  output logic [N_CH/2-1:0]     resp,
  output logic                  clr_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ro_state_t               r_state;
  logic [WIN_W-1:0]        r_win_len;
  logic [WIN_W-1:0]        r_win_cnt;
  logic [N_CH*CNT_W-1:0]   r_cnt;
  logic [N_CH-1:0]         r_sat;
  logic [N_CH/2-1:0]       r_resp;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_clr_done;

  logic [N_CH-1:0]         w_edge;
  logic [N_CH*CNT_W-1:0]   w_inc;
  logic [N_CH-1:0]         w_sat_nxt;
  logic [N_CH/2-1:0]       w_resp_nxt;
  logic [N_CH*CNT_W-1:0]   w_cnt_d;
  logic [N_CH-1:0]         w_sat_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] w_cur;

    ro_edge_sync u_sync (
      .clk    (clk),
      .clr    (clr),
      .d      (ch_in[i]),
      .edge_p (w_edge[i])
    );

    assign w_cur = r_cnt[i*CNT_W +: CNT_W];

`ifdef RO_CNT_SATURATE_EN
    assign w_inc[i*CNT_W +: CNT_W] = (w_edge[i] && (w_cur != CNT_MAX)) ?
                                     w_cur + CNT_W'(1) : w_cur;
    assign w_sat_nxt[i] = r_sat[i] | (w_inc[i*CNT_W +: CNT_W] == CNT_MAX);
`else
    assign w_inc[i*CNT_W +: CNT_W] = w_edge[i] ? w_cur + CNT_W'(1) : w_cur;
    assign w_sat_nxt[i] = 1'b0;
`endif
  end

  // Responses are taken from the post-increment counts of the last COUNT
  // cycle so they line up with the counts during the done pulse.
  for (genvar k = 0; k < N_CH/2; k++) begin : g_resp
    assign w_resp_nxt[k] = w_inc[(2*k)*CNT_W +: CNT_W] >
                           w_inc[(2*k+1)*CNT_W +: CNT_W];
  end

  always_comb begin
    w_cnt_d = r_cnt;
    w_sat_d = r_sat;
    case (r_state)
      CLEAR: begin
        w_cnt_d = '0;
        w_sat_d = '0;
      end
      COUNT: begin
        w_cnt_d = w_inc;
        w_sat_d = w_sat_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_win_len  <= '0;
      r_win_cnt  <= '0;
      r_cnt      <= '0;
      r_sat      <= '0;
      r_resp     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr_done <= 1'b1;
    end else begin
      r_done     <= 1'b0;
      r_cnt      <= w_cnt_d;
      r_sat      <= w_sat_d;
      // Zero-detect on the value being loaded keeps clr_done aligned with cnt.
      r_clr_done <= (w_cnt_d == '0);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_win_len <= (win_len == '0) ? WIN_W'(1) : win_len;
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
          end
        end
        CLEAR: begin
          r_win_cnt <= '0;
          r_resp    <= '0;
          r_state   <= COUNT;
        end
        COUNT: begin
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          if (r_win_cnt == r_win_len - WIN_W'(1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_resp  <= w_resp_nxt;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign cnt      = r_cnt;
  assign sat      = r_sat;
  assign resp     = r_resp;
  assign clr_done = r_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_ro_window_counter.sv
// ---------------------------------------------------------------------------
// tb_ro_window_counter: directed self-checking bench for ro_window_counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ro_window_counter;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [23:0] win_len;
  logic [1:0]  ch_in;

  logic        busy_a, done_a, clr_done_a;
  logic [63:0] cnt_a;
  logic [1:0]  sat_a;
  logic [0:0]  resp_a;

  logic        busy_b, done_b, clr_done_b;
  logic [7:0]  cnt_b;
  logic [1:0]  sat_b;
  logic [0:0]  resp_b;

  int per0 = 0;
  int per1 = 0;
  int checks = 0;
  int failures = 0;

  ro_window_counter #(.N_CH(2), .CNT_W(32), .WIN_W(24)) dut (
    .clk(clk), .clr(clr), .start(start), .win_len(win_len), .ch_in(ch_in),
    .busy(busy_a), .done(done_a), .cnt(cnt_a), .sat(sat_a), .resp(resp_a),
    .clr_done(clr_done_a)
  );

  // Narrow-counter copy sharing the same stimulus, for the overflow case.
  ro_window_counter #(.N_CH(2), .CNT_W(4), .WIN_W(24)) dut_s (
    .clk(clk), .clr(clr), .start(start), .win_len(win_len), .ch_in(ch_in),
    .busy(busy_b), .done(done_b), .cnt(cnt_b), .sat(sat_b), .resp(resp_b),
    .clr_done(clr_done_b)
  );

  always #5 clk = ~clk;

  // Oscillator model: channel i toggles every per_i clk cycles (0 = held low).
  initial begin
    int ph0, ph1;
    ph0 = 0;
    ph1 = 0;
    ch_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (per0 == 0) begin ch_in[0] = 1'b0; ph0 = 0; end
      else if (ph0 >= per0 - 1) begin ch_in[0] = ~ch_in[0]; ph0 = 0; end
      else ph0++;
      if (per1 == 0) begin ch_in[1] = 1'b0; ph1 = 0; end
      else if (ph1 >= per1 - 1) begin ch_in[1] = ~ch_in[1]; ph1 = 0; end
      else ph1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge of the CLEAR cycle (n = 1).
  task automatic kick(input logic [23:0] len);
    start   = 1'b1;
    win_len = len;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, inout int n);
    while (done_a !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    start   = 1'b0;
    win_len = '0;
    clr     = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_a); end
    checks++; if (cnt_a !== 64'd0) begin failures++; $display("FAIL reset_cnt got=%h want=0", cnt_a); end
    checks++; if (sat_a !== 2'b00) begin failures++; $display("FAIL reset_sat got=%b want=00", sat_a); end
    checks++; if (resp_a !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b want=0", resp_a); end
    checks++; if (clr_done_a !== 1'b1) begin failures++; $display("FAIL reset_clr_done got=%b want=1", clr_done_a); end
    checks++; if (cnt_b !== 8'd0 || clr_done_b !== 1'b1) begin failures++; $display("FAIL reset_narrow got=%h/%b want=0/1", cnt_b, clr_done_b); end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_window;
    int n;
    per0 = 4;
    per1 = 8;
    repeat (20) @(negedge clk);
    kick(24'd100);
    n = 1;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy_a); end
    wait_done(200, n);
    checks++; if (done_a !== 1'b1 || n != 102) begin failures++; $display("FAIL basic_done_time got=%0d want=102", n); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%b want=0", busy_a); end
    checks++; if (cnt_a[31:0] !== 32'd12 && cnt_a[31:0] !== 32'd13) begin failures++; $display("FAIL basic_cnt0 got=%0d want=12or13", cnt_a[31:0]); end
    checks++; if (cnt_a[63:32] !== 32'd6 && cnt_a[63:32] !== 32'd7) begin failures++; $display("FAIL basic_cnt1 got=%0d want=6or7", cnt_a[63:32]); end
    checks++; if (resp_a !== 1'b1) begin failures++; $display("FAIL basic_resp got=%b want=1", resp_a); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", done_a); end
    checks++; if (resp_a !== 1'b1 || clr_done_a !== 1'b0) begin failures++; $display("FAIL basic_hold got=%b/%b want=1/0", resp_a, clr_done_a); end
  endtask

  task automatic test_zero_window;
    int n;
    per0 = 0;
    per1 = 0;
    repeat (8) @(negedge clk);
    kick(24'd0);
    n = 1;
    checks++; if (clr_done_a !== 1'b0) begin failures++; $display("FAIL zero_clr_done_t1 got=%b want=0", clr_done_a); end
    @(negedge clk);
    n++;
    checks++; if (clr_done_a !== 1'b1) begin failures++; $display("FAIL zero_clr_done_t2 got=%b want=1", clr_done_a); end
    wait_done(20, n);
    checks++; if (done_a !== 1'b1 || n != 3) begin failures++; $display("FAIL zero_done_time got=%0d want=3", n); end
    checks++; if (cnt_a !== 64'd0 || resp_a !== 1'b0) begin failures++; $display("FAIL zero_cnt_resp got=%h/%b want=0/0", cnt_a, resp_a); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int n;
    per0 = 2;
    repeat (10) @(negedge clk);
    kick(24'd64);
    n = 1;
    wait_done(120, n);
    checks++; if (done_a !== 1'b1 || n != 66) begin failures++; $display("FAIL sat_done_time got=%0d want=66", n); end
    checks++; if (cnt_a !== {32'd0, 32'd16}) begin failures++; $display("FAIL sat_wide_cnt got=%h want=16", cnt_a); end
    checks++; if (sat_a !== 2'b00 || resp_a !== 1'b1) begin failures++; $display("FAIL sat_wide_flags got=%b/%b want=00/1", sat_a, resp_a); end
`ifdef RO_CNT_SATURATE_EN
    checks++; if (cnt_b !== 8'h0F) begin failures++; $display("FAIL sat_narrow_cnt got=%h want=0f", cnt_b); end
    checks++; if (sat_b !== 2'b01) begin failures++; $display("FAIL sat_narrow_sat got=%b want=01", sat_b); end
    checks++; if (resp_b !== 1'b1) begin failures++; $display("FAIL sat_narrow_resp got=%b want=1", resp_b); end
`else
    checks++; if (cnt_b !== 8'h00) begin failures++; $display("FAIL sat_narrow_cnt got=%h want=00", cnt_b); end
    checks++; if (sat_b !== 2'b00) begin failures++; $display("FAIL sat_narrow_sat got=%b want=00", sat_b); end
    checks++; if (resp_b !== 1'b0) begin failures++; $display("FAIL sat_narrow_resp got=%b want=0", resp_b); end
`endif
    per0 = 0;
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int n;
    int extra;
    repeat (6) @(negedge clk);
    kick(24'd30);
    n = 1;
    while (done_a !== 1'b1 && n < 100) begin
      start = (n == 10);
      if (n == 10) win_len = 24'd50;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++; if (done_a !== 1'b1 || n != 32) begin failures++; $display("FAIL busy_done_time got=%0d want=32", n); end
    // Start raised in DONE is ignored, then held into IDLE it is accepted.
    start   = 1'b1;
    win_len = 24'd5;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL busy_start_in_done got=%b want=0", busy_a); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL busy_start_in_idle got=%b want=1", busy_a); end
    n = 1;
    wait_done(40, n);
    checks++; if (done_a !== 1'b1 || n != 7) begin failures++; $display("FAIL busy_second_done got=%0d want=7", n); end
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL busy_no_retrigger got=%0d want=0", extra); end
  endtask

  task automatic test_mid_reset;
    int n;
    int extra;
    per0 = 4;
    repeat (6) @(negedge clk);
    kick(24'd100);
    n = 1;
    extra = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done_a === 1'b1) extra++;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL midclr_state got=%b/%b want=0/0", busy_a, done_a); end
    checks++; if (cnt_a !== 64'd0 || clr_done_a !== 1'b1) begin failures++; $display("FAIL midclr_cnt got=%h/%b want=0/1", cnt_a, clr_done_a); end
    checks++; if (sat_a !== 2'b00 || resp_a !== 1'b0) begin failures++; $display("FAIL midclr_flags got=%b/%b want=00/0", sat_a, resp_a); end
    repeat (110) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL midclr_no_done got=%0d want=0", extra); end
    kick(24'd20);
    n = 1;
    wait_done(60, n);
    checks++; if (done_a !== 1'b1 || n != 22) begin failures++; $display("FAIL midclr_restart_time got=%0d want=22", n); end
    checks++; if (cnt_a[31:0] !== 32'd2 && cnt_a[31:0] !== 32'd3) begin failures++; $display("FAIL midclr_restart_cnt got=%0d want=2or3", cnt_a[31:0]); end
    per0 = 0;
    @(negedge clk);
  endtask

  initial begin
    clr     = 1'b1;
    start   = 1'b0;
    win_len = '0;
    test_reset();
    test_basic_window();
    test_zero_window();
    test_saturation();
    test_start_while_busy();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
